synth_frame_loader: RTL and testbench

//  Upstream of the synth_t consumers. Receives the MCU->FPGA control stream as bytes from the SPI

---
 rtl/synth_frame_loader.sv | 89 ++++++++
 tb/tb_synth_frame_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/synth_frame_loader.sv
// synth_frame_loader: frames SYNC+payload+XOR checksum byte stream, commits payload image atomically.
module synth_frame_loader #(
  parameter int                         FRAME_BYTES    = 4,
  parameter logic [7:0]                 SYNC_BYTE      = 8'hA5,
  parameter int                         TIMEOUT_CYCLES = 100000,
  parameter logic [8*FRAME_BYTES-1:0]   RESET_FRAME    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [8*FRAME_BYTES-1:0]   synth_out,
  output logic                       frame_valid,
  output logic                       crc_err,
  output logic                       timeout_err
);
  localparam int W  = 8*FRAME_BYTES;
  localparam int CW = $clog2(FRAME_BYTES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [W-1:0]    shadow_q, shadow_d, synth_q, synth_d;
  logic            fv_q, fv_d, crc_q, crc_d, to_q, to_d;
  logic            take, in_frame, expired, hunting, start;
  assign in_ready = state_q != COMMIT;
  assign take     = in_valid && in_ready;
  assign in_frame = state_q == PAYLOAD || state_q == CHECK;
  assign expired  = in_frame && timer_q == TW'(TIMEOUT_CYCLES-1);
  // a byte arriving as the timer expires is handled as if the loader were already idle
  assign hunting  = expired || state_q == IDLE;
  assign start    = hunting && take && in_data == SYNC_BYTE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      timer_q  <= '0;
      shadow_q <= '0;
      synth_q  <= RESET_FRAME;
      fv_q     <= 1'b0;
      crc_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      synth_q  <= synth_d;
      fv_q     <= fv_d;
      crc_q    <= crc_d;
      to_q     <= to_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (hunting) state_d = start ? PAYLOAD : IDLE;
    else if (state_q == COMMIT) state_d = IDLE;
    else if (take && state_q == PAYLOAD) state_d = cnt_q == CW'(FRAME_BYTES-1) ? CHECK : PAYLOAD;
    else if (take) state_d = in_data == csum_q ? COMMIT : IDLE;
  end
  always_comb begin
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    timer_d  = (in_frame && !take && !expired) ? timer_q + 1'b1 : '0;
    fv_d     = state_q == COMMIT;
    synth_d  = fv_d ? shadow_q : synth_q;
    crc_d    = !hunting && state_q == CHECK && take && in_data != csum_q;
    to_d     = expired;
    if (start) begin
      cnt_d    = '0;
      csum_d   = '0;
      shadow_d = '0;
    end else if (!hunting && state_q == PAYLOAD && take) begin
      shadow_d = (shadow_q << 8) | W'(in_data);
      csum_d   = csum_q ^ in_data;
      cnt_d    = cnt_q + 1'b1;
    end
  end
  assign synth_out   = synth_q;
  assign frame_valid = fv_q;
  assign crc_err     = crc_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_synth_frame_loader.sv
// tb_synth_frame_loader: directed scenarios for synth_frame_loader with hand-computed expectations.
module tb_synth_frame_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] synth_out;
  logic        frame_valid, crc_err, timeout_err;
  int checks = 0;
  int errors = 0;
  int fv_cnt = 0, crc_cnt = 0, to_cnt = 0, bad_pulse = 0;
  logic prev_any = 1'b0;
  synth_frame_loader #(
    .FRAME_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16), .RESET_FRAME(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .synth_out(synth_out), .frame_valid(frame_valid), .crc_err(crc_err), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    fv_cnt  <= fv_cnt + int'(frame_valid);
    crc_cnt <= crc_cnt + int'(crc_err);
    to_cnt  <= to_cnt + int'(timeout_err);
    if ((int'(frame_valid) + int'(crc_err) + int'(timeout_err) > 1) ||
        (prev_any && (frame_valid || crc_err || timeout_err))) bad_pulse <= bad_pulse + 1;
    prev_any <= frame_valid || crc_err || timeout_err;
  end
  task automatic clear_counts();
    @(negedge clk);
    #1 fv_cnt = 0; crc_cnt = 0; to_cnt = 0;
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 4 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (synth_out !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_synth got %h exp DEADBEEF", synth_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if ({frame_valid, crc_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {frame_valid, crc_err, timeout_err}); end
  endtask
  task automatic test_good_frame();
    clear_counts();
    send(8'hA5); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    @(negedge clk);
    checks++; if (synth_out !== 32'hDEADBEEF) begin errors++; $display("FAIL good_early got %h exp DEADBEEF", synth_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL good_commit_ready got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (synth_out !== 32'h11223344) begin errors++; $display("FAIL good_synth got %h exp 11223344", synth_out); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_fv got %b exp 1", frame_valid); end
    repeat (3) @(negedge clk);
    checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL good_fv_count got %0d exp 1", fv_cnt); end
  endtask
  task automatic test_bad_crc();
    clear_counts();
    send(8'hA5); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h45);
    @(negedge clk);
    checks++; if (crc_err !== 1'b1) begin errors++; $display("FAIL crc_pulse got %b exp 1", crc_err); end
    repeat (3) @(negedge clk);
    checks++; if (crc_cnt !== 1) begin errors++; $display("FAIL crc_count got %0d exp 1", crc_cnt); end
    checks++; if (fv_cnt !== 0) begin errors++; $display("FAIL crc_no_fv got %0d exp 0", fv_cnt); end
    checks++; if (synth_out !== 32'h11223344) begin errors++; $display("FAIL crc_synth got %h exp 11223344", synth_out); end
  endtask
  task automatic test_junk_and_sync_data();
    logic [7:0] seq [9] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    clear_counts();
    foreach (seq[i]) send(seq[i]);
    repeat (4) @(negedge clk);
    checks++; if (synth_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL junk_synth got %h exp A5A5A5A5", synth_out); end
    checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL junk_fv_count got %0d exp 1", fv_cnt); end
    checks++; if (crc_cnt !== 0) begin errors++; $display("FAIL junk_crc_count got %0d exp 0", crc_cnt); end
  endtask
  task automatic test_timeout();
    clear_counts();
    send(8'hA5); send(8'h11);
    repeat (14) @(negedge clk);
    checks++; if (to_cnt !== 0) begin errors++; $display("FAIL timeout_early got %0d exp 0", to_cnt); end
    repeat (6) @(negedge clk);
    checks++; if (to_cnt !== 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", to_cnt); end
    checks++; if (synth_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL timeout_synth got %h exp A5A5A5A5", synth_out); end
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    repeat (3) @(negedge clk);
    checks++; if (synth_out !== 32'h01020304) begin errors++; $display("FAIL after_timeout_synth got %h exp 01020304", synth_out); end
    checks++; if (fv_cnt !== 1 || to_cnt !== 1) begin errors++; $display("FAIL after_timeout_counts got fv=%0d to=%0d exp fv=1 to=1", fv_cnt, to_cnt); end
  endtask
  task automatic test_back_to_back();
    send(8'hA5); send(8'h11); send(8'h22);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    checks++; if (synth_out !== 32'hDEADBEEF) begin errors++; $display("FAIL midreset_synth got %h exp DEADBEEF", synth_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", in_ready); end
    send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h08);
    in_data = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_commit_ready got %b exp 0", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (synth_out !== 32'h12345678) begin errors++; $display("FAIL midreset_frame got %h exp 12345678", synth_out); end
    send(8'hA5); send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0); send(8'h08);
    repeat (3) @(negedge clk);
    checks++; if (synth_out !== 32'h9ABCDEF0) begin errors++; $display("FAIL hold_not_consumed got %h exp 9ABCDEF0", synth_out); end
    checks++; if (fv_cnt !== 2 || crc_cnt !== 0 || to_cnt !== 0) begin errors++; $display("FAIL b2b_counts got fv=%0d crc=%0d to=%0d exp 2 0 0", fv_cnt, crc_cnt, to_cnt); end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_junk_and_sync_data();
    test_timeout();
    test_back_to_back();
    checks++; if (bad_pulse !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d exp 0", bad_pulse); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
